pipe_funnel_out: RTL and testbench
==================================

// Module: pipe_funnel_out
// PURPOSE
//  Width-narrowing drain stage directly downstream of the Fifo1Base/FifoB1Base out interface.
//  Each FIFO entry is one packet: HDR_WIDTH-bit header in the low bits, PAYLOAD_WIDTH-bit payload above it.
//  Per entry: dequeues it, captures it, emits 1 header beat then N payload beats of DATA_WIDTH bits on a PipeIn-style enq port.
//  Back-to-back reload keeps the output port 100% busy when upstream has data.
// PARAMETERS
//  DATA_WIDTH     32    output beat width; HDR_WIDTH <= DATA_WIDTH
//  HDR_WIDTH      16    header width; header[LEN_BITS-1:0] = payload word count N
//  PAYLOAD_WIDTH  128   payload width; must be a multiple of DATA_WIDTH; WORDS = PAYLOAD_WIDTH/DATA_WIDTH (4)
//  LEN_BITS       3     width of length field, = clog2(WORDS+1)
// PORTS
//  CLK            in   1                        clock, all state on rising edge
//  RST            in   1                        synchronous, active-high reset
//  in$first       in   HDR_WIDTH+PAYLOAD_WIDTH  head entry of upstream FIFO
//  in$first__RDY  in   1                        in$first valid
//  in$deq__RDY    in   1                        upstream deq permitted
//  in$deq__ENA    out  1                        dequeue head entry this cycle
//  out$enq$v      out  DATA_WIDTH+1             beat data; bit DATA_WIDTH = last-beat flag
//  out$enq__RDY   in   1                        downstream can accept a beat
//  out$enq__ENA   out  1                        beat transferred this cycle
// BEHAVIOUR
//  Handshake: a method fires in the cycle its __ENA is high; __ENA is never high unless the matching __RDY
//   (for in: in$deq__RDY && in$first__RDY) is high in that same cycle. No combinational path out$enq__RDY -> in$deq__ENA except the reload case below.
//  State: IDLE, BUSY; regs buf[HDR_WIDTH+PAYLOAD_WIDTH-1:0], cnt[LEN_BITS-1:0], last_idx[LEN_BITS-1:0].
//  Length: N = header[LEN_BITS-1:0]; N > WORDS is clamped to WORDS; N = 0 is legal (header-only packet).
//  IDLE: in$deq__ENA = in$deq__RDY & in$first__RDY. On fire: buf <= in$first, cnt <= 0, last_idx <= clamp(N), -> BUSY.
//   out$enq__ENA = 0 in IDLE. Latency: entry captured cycle t, header beat earliest at t+1.
//  BUSY: out$enq__ENA = out$enq__RDY.
//   out$enq$v[DATA_WIDTH-1:0] = (cnt==0) ? zero-extended header : buf payload word (cnt-1), word 0 = payload LSBs.
//   out$enq$v[DATA_WIDTH] = (cnt == last_idx).
//   Fire with cnt != last_idx: cnt <= cnt+1.
//   Fire with cnt == last_idx: if in$deq__RDY & in$first__RDY then in$deq__ENA = 1, reload buf/cnt/last_idx
//    as in IDLE, stay BUSY (no bubble); else -> IDLE.
//   No fire (out$enq__RDY = 0): all regs hold; out$enq$v stable; in$deq__ENA = 0.
//  Beats per packet = clamp(N)+1; header occupies its own beat even if HDR_WIDTH < DATA_WIDTH.
//  out$enq$v is driven to 0 in IDLE.
//  Reset (RST high at edge): state IDLE, buf 0, cnt 0, last_idx 0; next cycle in$deq__ENA = 0 (until RDY),
//   out$enq__ENA = 0, out$enq$v = 0. Reset mid-packet drops the remaining beats; the captured entry is not restored.
//  RST dominates any same-cycle fire; deq/enq outputs are 0 while RST is high.
// TESTING
//  1 Reset: hold RST 2 cycles, in$first__RDY=1 -> in$deq__ENA=0, out$enq__ENA=0, out$enq$v=0 during reset.
//  2 Single packet: entry hdr=16'h0004, payload=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, out RDY=1 ->
//    beats {0,00000004},{0,AAAAAAAA},{0,BBBBBBBB},{0,CCCCCCCC},{1,DDDDDDDD} on 5 consecutive cycles; one deq.
//  3 Back-to-back: 3 queued entries with N=2 -> 9 beats in 9 consecutive cycles, deq fires in the cycle of each last beat.
//  4 Boundary lengths: hdr=16'h0000 -> single beat {1,00000000}; hdr=16'h0007 -> clamped to 4 payload beats, 5 total.
//  5 Backpressure: out$enq__RDY toggles 1,0,0,1 mid-packet -> out$enq$v holds stable while RDY=0, no beat lost or duplicated.
//  6 Reset mid-packet: RST after beat 2 of 5 -> no further beats; next entry restarts at header beat.

Source files
------------

// File: rtl/pipe_funnel_out.sv
// -----------------------------------------------------------------------------
// pipe_funnel_out
//
// Width-narrowing drain stage that sits directly downstream of a FIFO "out"
// interface. Each FIFO entry is one packet: HDR_WIDTH-bit header in the low
// bits and PAYLOAD_WIDTH-bit payload above it. Each entry is dequeued and
// captured, then emitted as one header beat followed by N payload beats of
// DATA_WIDTH bits. N is header[LEN_BITS-1:0], clamped to WORDS.
//
// When the last beat of a packet fires and the next entry is already
// available, the next entry is reloaded in the same cycle. This keeps the
// output port fully busy while upstream has data.
//
// Ports
//   clk           in   clock; all state updates on the rising edge
//   rst           in   synchronous, active-high reset
//   in_first      in   head entry of the upstream FIFO {payload, header}
//   in_first_rdy  in   in_first is valid
//   in_deq_rdy    in   upstream permits a dequeue
//   in_deq_ena    out  dequeue the head entry this cycle
//   out_enq_v     out  beat data; bit DATA_WIDTH is the last-beat flag
//   out_enq_rdy   in   downstream can accept a beat
//   out_enq_ena   out  a beat transfers this cycle
// -----------------------------------------------------------------------------
module pipe_funnel_out #(
  parameter int DATA_WIDTH    = 32,
  parameter int HDR_WIDTH     = 16,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int LEN_BITS      = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [HDR_WIDTH+PAYLOAD_WIDTH-1:0] in_first,
  input  logic                               in_first_rdy,
  input  logic                               in_deq_rdy,
  output logic                               in_deq_ena,
  output logic [DATA_WIDTH:0]                out_enq_v,
  input  logic                               out_enq_rdy,
  output logic                               out_enq_ena
);

  localparam int WORDS   = PAYLOAD_WIDTH / DATA_WIDTH;
  localparam int ENTRY_W = HDR_WIDTH + PAYLOAD_WIDTH;
  localparam int WIDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   buf_q, buf_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic [LEN_BITS-1:0]  last_idx_q, last_idx_d;

  logic                 in_avail;
  logic                 at_last;
  logic                 load;
  logic [LEN_BITS-1:0]  in_len;
  logic [LEN_BITS-1:0]  in_len_clamped;
  logic [WORDS-1:0][DATA_WIDTH-1:0] pay_words;
  logic [WIDX_W-1:0]    word_idx;

  assign in_avail       = in_deq_rdy & in_first_rdy;
  assign in_len         = in_first[LEN_BITS-1:0];
  assign in_len_clamped = (in_len > LEN_BITS'(WORDS)) ? LEN_BITS'(WORDS) : in_len;
  assign at_last        = (cnt_q == last_idx_q);

  // Payload as an array of output words; word 0 holds the payload LSBs.
  assign pay_words = buf_q[ENTRY_W-1:HDR_WIDTH];
  // Beat 0 is the header, so payload word k goes out on beat k+1.
  assign word_idx  = WIDX_W'(cnt_q - LEN_BITS'(1));

  // Handshake and next-state logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    in_deq_ena  = 1'b0;
    out_enq_ena = 1'b0;
    load        = 1'b0;
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    last_idx_d  = last_idx_q;

    case (state_q)
      IDLE: begin
        if (in_avail) begin
          in_deq_ena = 1'b1;
          load       = 1'b1;
        end
      end
      BUSY: begin
        out_enq_ena = out_enq_rdy;
        if (out_enq_rdy) begin
          if (!at_last) begin
            cnt_d = cnt_q + LEN_BITS'(1);
          end else if (in_avail) begin
            // Reload on the last beat. This is the only place where
            // out_enq_rdy reaches in_deq_ena combinationally.
            in_deq_ena = 1'b1;
            load       = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      buf_d      = in_first;
      cnt_d      = '0;
      last_idx_d = in_len_clamped;
      state_d    = BUSY;
    end

    // Reset wins over any fire in the same cycle.
    if (rst) begin
      in_deq_ena  = 1'b0;
      out_enq_ena = 1'b0;
    end
  end

  // Beat data: zero-extended header on beat 0, then payload words.
  // The port reads as zero whenever no packet is being emitted.
  always_comb begin
    out_enq_v = '0;
    if (state_q == BUSY && !rst) begin
      out_enq_v[DATA_WIDTH]     = at_last;
      out_enq_v[DATA_WIDTH-1:0] = (cnt_q == '0) ? DATA_WIDTH'(buf_q[HDR_WIDTH-1:0])
                                                : pay_words[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the packet buffer is a plain register, not a memory, and it is
    // cleared on reset so its contents are never stale after reset.
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples values from before the edge, whatever the statement order.
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_pipe_funnel_out.sv
// -----------------------------------------------------------------------------
// tb_pipe_funnel_out
//
// Directed bench for pipe_funnel_out. A table of per-cycle vectors covers
// reset, a single packet and the boundary lengths. Hand-written sequences
// cover back-to-back reload, backpressure and reset mid-packet.
//
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_funnel_out;

  localparam int DW = 32;
  localparam int HW = 16;
  localparam int PW = 128;
  localparam int EW = HW + PW;

  logic          clk;
  logic          rst;
  logic [EW-1:0] in_first;
  logic          in_first_rdy;
  logic          in_deq_rdy;
  logic          in_deq_ena;
  logic [DW:0]   out_enq_v;
  logic          out_enq_rdy;
  logic          out_enq_ena;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_funnel_out #(
    .DATA_WIDTH   (DW),
    .HDR_WIDTH    (HW),
    .PAYLOAD_WIDTH(PW),
    .LEN_BITS     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_first    (in_first),
    .in_first_rdy(in_first_rdy),
    .in_deq_rdy  (in_deq_rdy),
    .in_deq_ena  (in_deq_ena),
    .out_enq_v   (out_enq_v),
    .out_enq_rdy (out_enq_rdy),
    .out_enq_ena (out_enq_ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          frdy;
    logic          drdy;
    logic [EW-1:0] first;
    logic          ordy;
    logic          exp_deq;
    logic          exp_enq;
    logic [DW:0]   exp_v;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and check all three outputs.
  task automatic step(input logic r, input logic fr, input logic dr, input logic [EW-1:0] f,
                      input logic orr, input logic e_deq, input logic e_enq,
                      input logic [DW:0] e_v, input string tag);
    @(negedge clk);
    rst          = r;
    in_first_rdy = fr;
    in_deq_rdy   = dr;
    in_first     = f;
    out_enq_rdy  = orr;
    #1;
    check({tag, " deq_ena"}, {{DW{1'b0}}, in_deq_ena},  {{DW{1'b0}}, e_deq});
    check({tag, " enq_ena"}, {{DW{1'b0}}, out_enq_ena}, {{DW{1'b0}}, e_enq});
    check({tag, " enq_v"},   out_enq_v, e_v);
  endtask

  function automatic vec_t mk(input logic r, input logic fr, input logic dr, input logic [EW-1:0] f,
                              input logic orr, input logic e_deq, input logic e_enq,
                              input logic [DW:0] e_v);
    vec_t v;
    v.rst = r; v.frdy = fr; v.drdy = dr; v.first = f; v.ordy = orr;
    v.exp_deq = e_deq; v.exp_enq = e_enq; v.exp_v = e_v;
    return v;
  endfunction

  // Entry with hdr=4 and four distinct payload words.
  localparam logic [EW-1:0] P1 = {128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0004};
  // Header-only packet; the payload must never appear on the port.
  localparam logic [EW-1:0] P0 = {128'h99999999_88888888_77777777_66666666, 16'h0000};
  // Length 7 is clamped to 4 payload beats.
  localparam logic [EW-1:0] P7 = {128'h44444444_33333333_22222222_11111111, 16'h0007};
  localparam logic [EW-1:0] Z  = '0;

  initial begin
    logic [EW-1:0]  q_ent [3];
    logic [DW-1:0]  bp_beats [5];
    logic [DW-1:0]  exp_word;
    logic           bp_ordy [7];
    int             idx;
    int             pkt;
    int             pos;
    logic           more;
    logic [EW-1:0]  e2;

    rst = 1'b1; in_first_rdy = 1'b0; in_deq_rdy = 1'b0; in_first = '0; out_enq_rdy = 1'b0;

    // ---- table: reset, single packet, boundary lengths ----
    vecs[0]  = mk(1, 1, 1, P1, 1, 0, 0, 33'h0);             // reset held, entry waiting
    vecs[1]  = mk(1, 1, 1, P1, 1, 0, 0, 33'h0);
    vecs[2]  = mk(0, 0, 1, Z,  1, 0, 0, 33'h0);             // idle, nothing upstream
    vecs[3]  = mk(0, 1, 1, P1, 1, 1, 0, 33'h0);             // capture P1
    vecs[4]  = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h00000004});
    vecs[5]  = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'hAAAAAAAA});
    vecs[6]  = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'hBBBBBBBB});
    vecs[7]  = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'hCCCCCCCC});
    vecs[8]  = mk(0, 0, 1, Z,  1, 0, 1, {1'b1, 32'hDDDDDDDD});
    vecs[9]  = mk(0, 0, 1, Z,  1, 0, 0, 33'h0);
    vecs[10] = mk(0, 1, 1, P0, 1, 1, 0, 33'h0);             // capture N=0
    vecs[11] = mk(0, 0, 1, Z,  1, 0, 1, {1'b1, 32'h00000000});
    vecs[12] = mk(0, 0, 1, Z,  1, 0, 0, 33'h0);
    vecs[13] = mk(0, 1, 1, P7, 1, 1, 0, 33'h0);             // capture N=7
    vecs[14] = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h00000007});
    vecs[15] = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h11111111});
    vecs[16] = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h22222222});
    vecs[17] = mk(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h33333333});
    vecs[18] = mk(0, 0, 1, Z,  1, 0, 1, {1'b1, 32'h44444444});
    vecs[19] = mk(0, 0, 1, Z,  1, 0, 0, 33'h0);
    vecs[20] = mk(0, 1, 0, P1, 1, 0, 0, 33'h0);             // first valid but deq not permitted

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].frdy, vecs[i].drdy, vecs[i].first, vecs[i].ordy,
           vecs[i].exp_deq, vecs[i].exp_enq, vecs[i].exp_v, $sformatf("vec%0d", i));
    end

    // ---- back-to-back: three N=2 entries -> 9 beats in 9 cycles ----
    for (int k = 0; k < 3; k++) begin
      q_ent[k] = {64'h0, {8{4'(k + 1)}}, {4{4'(k + 1), 4'hA}}, 16'h0002};
    end
    step(0, 1, 1, q_ent[0], 1, 1, 0, 33'h0, "b2b load0");
    for (int b = 0; b < 9; b++) begin
      pkt  = b / 3;
      pos  = b % 3;
      more = (pkt + 1 < 3);
      if (pos == 0)      exp_word = 32'h00000002;
      else if (pos == 1) exp_word = q_ent[pkt][HW +: DW];
      else               exp_word = q_ent[pkt][HW + DW +: DW];
      step(0, more, 1, more ? q_ent[(pkt + 1) % 3] : Z, 1,
           (pos == 2) && more, 1, {pos == 2, exp_word}, $sformatf("b2b beat%0d", b));
    end
    step(0, 0, 1, Z, 1, 0, 0, 33'h0, "b2b idle");

    // ---- backpressure mid-packet: RDY 1,1,0,0,1,1,1 ----
    bp_beats[0] = 32'h00000004; bp_beats[1] = 32'hAAAAAAAA; bp_beats[2] = 32'hBBBBBBBB;
    bp_beats[3] = 32'hCCCCCCCC; bp_beats[4] = 32'hDDDDDDDD;
    bp_ordy[0] = 1; bp_ordy[1] = 1; bp_ordy[2] = 0; bp_ordy[3] = 0;
    bp_ordy[4] = 1; bp_ordy[5] = 1; bp_ordy[6] = 1;
    step(0, 1, 1, P1, 0, 1, 0, 33'h0, "bp load");
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 1, Z, bp_ordy[c], 0, bp_ordy[c], {idx == 4, bp_beats[idx]},
           $sformatf("bp cyc%0d", c));
      if (bp_ordy[c]) idx++;
    end
    step(0, 0, 1, Z, 1, 0, 0, 33'h0, "bp idle");

    // ---- reset mid-packet: after beat 2 of 5, then restart on next entry ----
    e2 = {96'h0, 32'h55555555, 16'h0001};
    step(0, 1, 1, P1, 1, 1, 0, 33'h0, "rmp load");
    step(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h00000004}, "rmp beat1");
    step(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'hAAAAAAAA}, "rmp beat2");
    step(1, 1, 1, e2, 1, 0, 0, 33'h0, "rmp in_reset");
    step(0, 1, 1, e2, 1, 1, 0, 33'h0, "rmp reload");
    step(0, 0, 1, Z,  1, 0, 1, {1'b0, 32'h00000001}, "rmp hdr");
    step(0, 0, 1, Z,  1, 0, 1, {1'b1, 32'h55555555}, "rmp word0");
    step(0, 0, 1, Z,  1, 0, 0, 33'h0, "rmp idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
